// File: rtl/gerador_sequencia.sv
// rtl/gerador_sequencia.sv - serial word transmitter, MSB first, with repetitions and idle gaps.
// Optional trailing even-parity bit per word when GERADOR_SEQUENCIA_PARIDADE_EN is defined.
module gerador_sequencia #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             setar_palavra,
  input  logic [WIDTH-1:0] palavra,
  input  logic [REP_W-1:0] num_rep,
  input  logic             start,
  input  logic             parar,
  output logic             bit_out,
  output logic             bit_valido,
  output logic             ocupado,
  output logic             concluido
);

`ifdef GERADOR_SEQUENCIA_PARIDADE_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1 + PAR);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {OCIOSO, ENVIA, PAUSA, FIM} estado_t;

  estado_t          estado, estado_prox;
  logic [WIDTH-1:0] palavra_reg, palavra_tx, shift_reg;
  logic [REP_W-1:0] num_rep_reg, rep_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             carregar, recarregar, ultima_rep, fim_palavra;

  assign fim_palavra = (bit_cnt == BIT_LAST);
  // num_rep = 0 never matches, so the transmission runs until parar
  assign ultima_rep  = (num_rep_reg != '0) && (rep_cnt == num_rep_reg);

  always_comb begin
    estado_prox = estado;
    carregar    = 1'b0;
    recarregar  = 1'b0;
    bit_out     = 1'b0;
    bit_valido  = 1'b0;
    ocupado     = 1'b0;
    concluido   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (start) begin
          estado_prox = ENVIA;
          carregar    = 1'b1;
        end
      end
      ENVIA: begin
        ocupado    = 1'b1;
        bit_valido = 1'b1;
`ifdef GERADOR_SEQUENCIA_PARIDADE_EN
        bit_out = (bit_cnt == BW'(WIDTH)) ? ^palavra_tx : shift_reg[WIDTH-1];
`else
        bit_out = shift_reg[WIDTH-1];
`endif
        if (fim_palavra) begin
          if (ultima_rep)
            estado_prox = FIM;
          else if (GAP > 0)
            estado_prox = PAUSA;
          else
            recarregar = 1'b1;
        end
      end
      PAUSA: begin
        ocupado = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          estado_prox = ENVIA;
          recarregar  = 1'b1;
        end
      end
      FIM: begin
        concluido   = 1'b1;
        estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
    if (parar && estado != OCIOSO) begin
      estado_prox = OCIOSO;
      recarregar  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      palavra_reg <= '0;
      palavra_tx  <= '0;
      shift_reg   <= '0;
      num_rep_reg <= '0;
      rep_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      estado <= estado_prox;
      if (setar_palavra)
        palavra_reg <= palavra;
      if (carregar) begin
        // a word written in the start cycle goes straight to the transmitter
        palavra_tx  <= setar_palavra ? palavra : palavra_reg;
        shift_reg   <= setar_palavra ? palavra : palavra_reg;
        num_rep_reg <= num_rep;
        rep_cnt     <= REP_W'(1);
        bit_cnt     <= '0;
        gap_cnt     <= '0;
      end else if (recarregar) begin
        shift_reg <= palavra_tx;
        bit_cnt   <= '0;
        gap_cnt   <= '0;
        if (rep_cnt != '1)
          rep_cnt <= rep_cnt + REP_W'(1);
      end else if (estado == ENVIA) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt + BW'(1);
        gap_cnt   <= '0;
      end else if (estado == PAUSA) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

endmodule

// File: doc/gerador_sequencia.md
Name: gerador_sequencia

Overview:
- Serial pattern transmitter; the transmit-side counterpart of the serial word detector (Sequencia).
- Holds a programmable WIDTH-bit word and, on start, shifts it out MSB-first, one bit per clk, repeated a programmable number of times with optional idle gaps.
- bit_out drives the detector's bit_in directly: the first bit sent ends up in the detector shift register MSB.

Parameters:
- WIDTH, 8, word length in bits.
- GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back).
- REP_W, 4, width of the repetition-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- setar_palavra  input  1  load palavra into the stored word this cycle.
- palavra  input  WIDTH  word to store.
- num_rep  input  REP_W  repetitions per start, sampled with start; 0 = continuous until parar.
- start  input  1  begin transmission; honoured only in OCIOSO.
- parar  input  1  abort transmission.
- bit_out  output  1  serial data; 0 whenever bit_valido=0.
- bit_valido  output  1  bit_out carries a word bit this cycle.
- ocupado  output  1  FSM not in OCIOSO.
- concluido  output  1  one-cycle pulse after a completed (non-aborted) transmission.

Behaviour:
- Reset (async assert, sync release): stored word=0, all outputs 0, FSM=OCIOSO, counters=0.
- Stored word: updated on any cycle with setar_palavra=1, including mid-transmission.
- At start, the stored word is copied into a transmit shift register. A word changed mid-transmission affects only the next start.
- If setar_palavra and start are in the same cycle, palavra (new value) is copied directly into the transmit register.
- States:
  - OCIOSO: outputs 0. start=1 -> ENVIA next cycle; latch num_rep; bit counter=0; repetition counter=1.
  - ENVIA: bit_out=shift[WIDTH-1], bit_valido=1, shift left each cycle. After WIDTH bits:
    - last repetition -> FIM.
    - else if GAP>0 -> PAUSA.
    - else reload the word and stay in ENVIA (next word's MSB in the very next cycle).
  - PAUSA: bit_out=0, bit_valido=0, ocupado=1 for exactly GAP cycles, then ENVIA with the word reloaded.
  - FIM: concluido=1, ocupado=0, bit_valido=0 for one cycle -> OCIOSO.
- Latency: start in cycle N -> MSB on bit_out in cycle N+1. A single repetition occupies cycles N+1..N+WIDTH; concluido is in cycle N+WIDTH+1.
- Last-repetition test: repetition counter == latched num_rep. num_rep=0 never terminates. The repetition counter saturates and does not wrap to a false match.
- The word reloaded for a repetition is the word latched at start, not the currently stored word.
- parar=1 in any state other than OCIOSO -> OCIOSO next cycle, all outputs 0, no concluido. parar has priority over start and over state transitions. parar in OCIOSO has no effect.
- start while ocupado=1 is ignored.
- Reset mid-transmission: immediate return to the reset state. The stored word is lost (becomes 0).

Optional Feature:
- Macro: GERADOR_SEQUENCIA_PARIDADE_EN.
- Defined: after each WIDTH data bits, one extra bit_valido=1 cycle carries the even parity (XOR) of the word. A repetition is WIDTH+1 cycles; GAP and concluido timing shift accordingly.
- Undefined: no parity bit; each repetition is exactly WIDTH cycles.

Test Plan:
- Reset, setar_palavra with palavra=8'hA5, start with num_rep=1 -> bit_out cycles 1..8 = 1,0,1,0,0,1,0,1 with bit_valido=1; concluido pulse at cycle 9; ocupado=1 for cycles 1..8 only.
- GAP=2, palavra=8'hC3, num_rep=3 -> C3 bits, 2 idle cycles, C3 bits, 2 idle cycles, C3 bits, then concluido; 28 busy cycles total. With GAP=0 -> 24 consecutive valid bits.
- Loopback into the detector: detector armed with 8'h5A, generator sends 8'h5A once -> detector encontrado asserts; generator sending 8'h5B -> encontrado stays 0.
- num_rep=0, palavra=8'hF0 -> continuous F0 pattern for 100 cycles; parar asserted -> next cycle all outputs 0, no concluido pulse.
- Mid-transmission setar_palavra=8'h00 during an 8'hFF send, then start ignored while busy -> current word stays all 1s; next start sends 8'h00.
- rst_n low at bit 4 of 8'h81 -> outputs 0 asynchronously; after release, start sends 8'h00 (stored word cleared).
